// File: rtl/dpram_sync_be_clr.sv
`default_nettype none
// ============================================================================
// Module   : dpram_sync_be_clr
// Purpose  : Single-clock, parametrised true dual-port RAM with per-lane byte
//            enables, selectable same-port read-during-write behaviour,
//            optional output register, deterministic cross-port collision
//            resolution (port A wins per lane), and a reset-triggered clear
//            engine that zeroes the whole array.
// Ports    : clock0          - sole clock, rising edge
//            reset           - synchronous active-high, starts clear sweep
//            busy            - high during reset and the clear sweep
//            rce_a / rce_b   - read enables
//            wce_a / wce_b   - write enables
//            addr_a / addr_b - word addresses
//            be_a / be_b     - byte-lane write enables
//            wd_a / wd_b     - write data
//            rq_a / rq_b     - read data
// Revision : 1.0 - initial release
// ============================================================================
module dpram_sync_be_clr #(
    parameter int    AWIDTH   = 10,
    parameter int    DWIDTH   = 36,
    parameter int    SIZE     = 1024,
    parameter int    BWIDTH   = 9,
    parameter int    OUT_REG  = 0,
    parameter string RDW_MODE = "READ_FIRST"
) (
    input  logic                       clock0,
    input  logic                       reset,
    output logic                       busy,
    input  logic                       rce_a,
    input  logic                       rce_b,
    input  logic                       wce_a,
    input  logic                       wce_b,
    input  logic [AWIDTH-1:0]          addr_a,
    input  logic [AWIDTH-1:0]          addr_b,
    input  logic [DWIDTH/BWIDTH-1:0]   be_a,
    input  logic [DWIDTH/BWIDTH-1:0]   be_b,
    input  logic [DWIDTH-1:0]          wd_a,
    input  logic [DWIDTH-1:0]          wd_b,
    output logic [DWIDTH-1:0]          rq_a,
    output logic [DWIDTH-1:0]          rq_b
);

    localparam int                c_nbytes      = DWIDTH / BWIDTH;
    localparam logic [0:0]        c_st_idle     = 1'b0;
    localparam logic [0:0]        c_st_clear    = 1'b1;
    localparam logic [AWIDTH-1:0] c_last_addr   = AWIDTH'(SIZE - 1);
    localparam bit                c_write_first = (RDW_MODE == "WRITE_FIRST");

    logic [DWIDTH-1:0] r_mem [0:SIZE-1];

    logic [0:0]        r_state;
    logic [AWIDTH-1:0] r_clr_ptr;
    logic [DWIDTH-1:0] r_rd_a;
    logic [DWIDTH-1:0] r_rd_b;

    logic              w_busy;
    logic              w_clr_we;
    logic              w_a_in_range;
    logic              w_b_in_range;
    logic              w_wr_a;
    logic              w_wr_b;
    logic [DWIDTH-1:0] w_old_a;
    logic [DWIDTH-1:0] w_old_b;
    logic [DWIDTH-1:0] w_merge_a;
    logic [DWIDTH-1:0] w_merge_b;
    logic [DWIDTH-1:0] w_rdata_a;
    logic [DWIDTH-1:0] w_rdata_b;

    // reset is folded in combinationally so busy is already high during the
    // cycles reset is held, not only after the first sampling edge.
    assign w_busy   = reset || (r_state == c_st_clear);
    assign busy     = w_busy;
    assign w_clr_we = (r_state == c_st_clear) && !reset;

    // When the array fills the whole address space every address is legal;
    // skipping the compare avoids a constant-true comparison.
    generate
        if (SIZE == (1 << AWIDTH)) begin : g_full_range
            assign w_a_in_range = 1'b1;
            assign w_b_in_range = 1'b1;
        end else begin : g_partial_range
            assign w_a_in_range = (addr_a < AWIDTH'(SIZE));
            assign w_b_in_range = (addr_b < AWIDTH'(SIZE));
        end
    endgenerate

    assign w_wr_a = wce_a && !w_busy && w_a_in_range;
    assign w_wr_b = wce_b && !w_busy && w_b_in_range;

    // ------------------------------------------------------------------------
    // Clear sequencer: one word per cycle while reset is low, then IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock0) begin
        if (reset) begin
            r_state   <= c_st_clear;
            r_clr_ptr <= '0;
        end else if (r_state == c_st_clear) begin
            if (r_clr_ptr == c_last_addr) begin
                r_state   <= c_st_idle;
                r_clr_ptr <= '0;
            end else begin
                r_clr_ptr <= r_clr_ptr + AWIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Array writes. Port B lanes are scheduled before port A lanes, so on a
    // same-address collision the later non-blocking update from A takes each
    // lane A enables, and B only lands in lanes A leaves alone.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock0) begin
        if (w_clr_we) begin
            r_mem[r_clr_ptr] <= '0;
        end else begin
            for (int k = 0; k < c_nbytes; k++) begin
                if (w_wr_b && be_b[k]) begin
                    r_mem[addr_b][k*BWIDTH +: BWIDTH] <= wd_b[k*BWIDTH +: BWIDTH];
                end
                if (w_wr_a && be_a[k]) begin
                    r_mem[addr_a][k*BWIDTH +: BWIDTH] <= wd_a[k*BWIDTH +: BWIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read data selection. The "old" word is the pre-edge array content,
    // which is also what a cross-port reader sees. WRITE_FIRST overlays only
    // the reading port's own enabled lanes on top of it.
    // ------------------------------------------------------------------------
    assign w_old_a = w_a_in_range ? r_mem[addr_a] : '0;
    assign w_old_b = w_b_in_range ? r_mem[addr_b] : '0;

    always_comb begin
        w_merge_a = w_old_a;
        w_merge_b = w_old_b;
        for (int k = 0; k < c_nbytes; k++) begin
            if (w_wr_a && be_a[k]) begin
                w_merge_a[k*BWIDTH +: BWIDTH] = wd_a[k*BWIDTH +: BWIDTH];
            end
            if (w_wr_b && be_b[k]) begin
                w_merge_b[k*BWIDTH +: BWIDTH] = wd_b[k*BWIDTH +: BWIDTH];
            end
        end
    end

    assign w_rdata_a = c_write_first ? w_merge_a : w_old_a;
    assign w_rdata_b = c_write_first ? w_merge_b : w_old_b;

    // Read registers: forced to zero while busy, otherwise load on rce and
    // hold between reads.
    always_ff @(posedge clock0) begin
        if (w_busy) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            if (rce_a) begin
                r_rd_a <= w_rdata_a;
            end
            if (rce_b) begin
                r_rd_b <= w_rdata_b;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional output stage, enabled every cycle (pure one-cycle delay).
    // ------------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] r_oq_a;
            logic [DWIDTH-1:0] r_oq_b;

            always_ff @(posedge clock0) begin
                if (w_busy) begin
                    r_oq_a <= '0;
                    r_oq_b <= '0;
                end else begin
                    r_oq_a <= r_rd_a;
                    r_oq_b <= r_rd_b;
                end
            end

            assign rq_a = r_oq_a;
            assign rq_b = r_oq_b;
        end else begin : g_no_out_reg
            assign rq_a = r_rd_a;
            assign rq_b = r_rd_b;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dpram_sync_be_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_sync_be_clr
// Purpose  : Directed, table-driven bench for dpram_sync_be_clr. Three
//            instances share one stimulus stream:
//              rf : OUT_REG=0, READ_FIRST,  SIZE=1024
//              wf : OUT_REG=0, WRITE_FIRST, SIZE=1024
//              oq : OUT_REG=1, READ_FIRST,  SIZE=1000 (addresses >= 1000
//                   are out of range for this instance)
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_sync_be_clr;

    localparam int AW = 10;
    localparam int DW = 36;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          rce_a, rce_b, wce_a, wce_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [NB-1:0] be_a, be_b;
    logic [DW-1:0] wd_a, wd_b;

    logic          busy_rf, busy_wf, busy_oq;
    logic [DW-1:0] rq_a_rf, rq_b_rf, rq_a_wf, rq_b_wf, rq_a_oq, rq_b_oq;

    int n_checks = 0;
    int n_errors = 0;

    dpram_sync_be_clr #(.AWIDTH(AW), .DWIDTH(DW), .SIZE(1024), .BWIDTH(9),
                        .OUT_REG(0), .RDW_MODE("READ_FIRST")) dut_rf (
        .clock0(clk), .reset(reset), .busy(busy_rf),
        .rce_a(rce_a), .rce_b(rce_b), .wce_a(wce_a), .wce_b(wce_b),
        .addr_a(addr_a), .addr_b(addr_b), .be_a(be_a), .be_b(be_b),
        .wd_a(wd_a), .wd_b(wd_b), .rq_a(rq_a_rf), .rq_b(rq_b_rf));

    dpram_sync_be_clr #(.AWIDTH(AW), .DWIDTH(DW), .SIZE(1024), .BWIDTH(9),
                        .OUT_REG(0), .RDW_MODE("WRITE_FIRST")) dut_wf (
        .clock0(clk), .reset(reset), .busy(busy_wf),
        .rce_a(rce_a), .rce_b(rce_b), .wce_a(wce_a), .wce_b(wce_b),
        .addr_a(addr_a), .addr_b(addr_b), .be_a(be_a), .be_b(be_b),
        .wd_a(wd_a), .wd_b(wd_b), .rq_a(rq_a_wf), .rq_b(rq_b_wf));

    dpram_sync_be_clr #(.AWIDTH(AW), .DWIDTH(DW), .SIZE(1000), .BWIDTH(9),
                        .OUT_REG(1), .RDW_MODE("READ_FIRST")) dut_oq (
        .clock0(clk), .reset(reset), .busy(busy_oq),
        .rce_a(rce_a), .rce_b(rce_b), .wce_a(wce_a), .wce_b(wce_b),
        .addr_a(addr_a), .addr_b(addr_b), .be_a(be_a), .be_b(be_b),
        .wd_a(wd_a), .wd_b(wd_b), .rq_a(rq_a_oq), .rq_b(rq_b_oq));

    typedef struct packed {
        logic          wa;
        logic          ra;
        logic [AW-1:0] aa;
        logic [NB-1:0] bea;
        logic [DW-1:0] wda;
        logic          wb;
        logic          rb;
        logic [AW-1:0] ab;
        logic [NB-1:0] beb;
        logic [DW-1:0] wdb;
        logic [DW-1:0] ea_rf;   // expected rq_a, READ_FIRST, after the edge
        logic [DW-1:0] ea_wf;   // expected rq_a, WRITE_FIRST
        logic [DW-1:0] eb_rf;
        logic [DW-1:0] eb_wf;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        rce_a = 1'b0; rce_b = 1'b0; wce_a = 1'b0; wce_b = 1'b0;
        addr_a = '0;  addr_b = '0;  be_a = '0;  be_b = '0;
        wd_a = '0;    wd_b = '0;
    endtask

    task automatic apply(input vec_t v);
        wce_a = v.wa; rce_a = v.ra; addr_a = v.aa; be_a = v.bea; wd_a = v.wda;
        wce_b = v.wb; rce_b = v.rb; addr_b = v.ab; be_b = v.beb; wd_b = v.wdb;
    endtask

    // One cycle of port-A/B traffic: drive at negedge, sample 1 ns after posedge.
    task automatic step(input logic wa, input logic ra, input logic [AW-1:0] aa,
                        input logic [DW-1:0] wda,
                        input logic rb, input logic [AW-1:0] ab);
        @(negedge clk);
        set_idle();
        wce_a = wa; rce_a = ra; addr_a = aa; be_a = 4'hF; wd_a = wda;
        rce_b = rb; addr_b = ab;
        @(posedge clk);
        #1;
    endtask

    // Counts edges from reset release until each instance drops busy.
    task automatic wait_clear(input string tag);
        int n       = 0;
        int fall_rf = -1;
        int fall_wf = -1;
        int fall_oq = -1;
        while ((busy_rf || busy_wf || busy_oq) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy_rf && fall_rf < 0) fall_rf = n;
            if (!busy_wf && fall_wf < 0) fall_wf = n;
            if (!busy_oq && fall_oq < 0) fall_oq = n;
        end
        chk($sformatf("%s busy window rf", tag), DW'(fall_rf), DW'(1024));
        chk($sformatf("%s busy window wf", tag), DW'(fall_wf), DW'(1024));
        chk($sformatf("%s busy window oq", tag), DW'(fall_oq), DW'(1000));
    endtask

    task automatic do_reset(input int cycles, input string tag);
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        chk($sformatf("%s busy in reset", tag), DW'({busy_rf, busy_wf, busy_oq}), DW'(3'b111));
        chk($sformatf("%s rq zero rf", tag), rq_a_rf | rq_b_rf, '0);
        chk($sformatf("%s rq zero wf", tag), rq_a_wf | rq_b_wf, '0);
        chk($sformatf("%s rq zero oq", tag), rq_a_oq | rq_b_oq, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk($sformatf("%s busy at release", tag), DW'(busy_rf), DW'(1));
        wait_clear(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] prev_a;
        logic [DW-1:0] prev_b;

        // Byte lanes are 9 bits: lane0=[8:0], lane1=[17:9], lane2=[26:18],
        // lane3=[35:27]. Lanes 1 and 3 all-ones -> 'hFF803FE00.
        //             wa    ra    aa      bea   wda            wb    rb    ab      beb   wdb            ea_rf          ea_wf          eb_rf          eb_wf
        vecs[0]  = '{1'b1, 1'b0, 10'd7,  4'hF, 36'hFFFFFFFFF, 1'b0, 1'b0, 10'd0,  4'h0, 36'h0,         36'h0,         36'h0,         36'h0,         36'h0};
        vecs[1]  = '{1'b1, 1'b0, 10'd7,  4'h5, 36'h000000000, 1'b0, 1'b0, 10'd0,  4'h0, 36'h0,         36'h0,         36'h0,         36'h0,         36'h0};
        vecs[2]  = '{1'b0, 1'b1, 10'd7,  4'h0, 36'h0,         1'b0, 1'b1, 10'd7,  4'h0, 36'h0,         36'hFF803FE00, 36'hFF803FE00, 36'hFF803FE00, 36'hFF803FE00};
        vecs[3]  = '{1'b1, 1'b0, 10'd3,  4'hF, 36'hAAAAAAAAA, 1'b0, 1'b0, 10'd0,  4'h0, 36'h0,         36'hFF803FE00, 36'hFF803FE00, 36'hFF803FE00, 36'hFF803FE00};
        // Same-port RDW on A, cross-port read on B of the same word.
        vecs[4]  = '{1'b1, 1'b1, 10'd3,  4'hF, 36'hBBBBBBBBB, 1'b0, 1'b1, 10'd3,  4'h0, 36'h0,         36'hAAAAAAAAA, 36'hBBBBBBBBB, 36'hAAAAAAAAA, 36'hAAAAAAAAA};
        vecs[5]  = '{1'b0, 1'b1, 10'd3,  4'h0, 36'h0,         1'b0, 1'b0, 10'd0,  4'h0, 36'h0,         36'hBBBBBBBBB, 36'hBBBBBBBBB, 36'hAAAAAAAAA, 36'hAAAAAAAAA};
        // Collision: A lanes 0,1 win, B fills lanes 2,3.
        vecs[6]  = '{1'b1, 1'b0, 10'd9,  4'h3, 36'h111111111, 1'b1, 1'b0, 10'd9,  4'hF, 36'h222222222, 36'hBBBBBBBBB, 36'hBBBBBBBBB, 36'hAAAAAAAAA, 36'hAAAAAAAAA};
        vecs[7]  = '{1'b0, 1'b1, 10'd9,  4'h0, 36'h0,         1'b0, 1'b1, 10'd9,  4'h0, 36'h0,         36'h222211111, 36'h222211111, 36'h222211111, 36'h222211111};
        // wce with all byte enables low is not a write.
        vecs[8]  = '{1'b0, 1'b0, 10'd0,  4'h0, 36'h0,         1'b1, 1'b0, 10'd20, 4'h0, 36'h123456789, 36'h222211111, 36'h222211111, 36'h222211111, 36'h222211111};
        vecs[9]  = '{1'b0, 1'b1, 10'd20, 4'h0, 36'h0,         1'b0, 1'b1, 10'd20, 4'h0, 36'h0,         36'h0,         36'h0,         36'h0,         36'h0};
        // Same-port RDW on B, cross-port read on A.
        vecs[10] = '{1'b0, 1'b1, 10'd21, 4'h0, 36'h0,         1'b1, 1'b1, 10'd21, 4'hF, 36'h0ABCDEF01, 36'h0,         36'h0,         36'h0,         36'h0ABCDEF01};
        vecs[11] = '{1'b0, 1'b1, 10'd21, 4'h0, 36'h0,         1'b0, 1'b0, 10'd0,  4'h0, 36'h0,         36'h0ABCDEF01, 36'h0ABCDEF01, 36'h0,         36'h0ABCDEF01};
        // No reads: outputs hold.
        vecs[12] = '{1'b1, 1'b0, 10'd21, 4'hF, 36'h555555555, 1'b0, 1'b0, 10'd0,  4'h0, 36'h0,         36'h0ABCDEF01, 36'h0ABCDEF01, 36'h0,         36'h0ABCDEF01};
        vecs[13] = '{1'b0, 1'b1, 10'd21, 4'h0, 36'h0,         1'b0, 1'b1, 10'd21, 4'h0, 36'h0,         36'h555555555, 36'h555555555, 36'h555555555, 36'h555555555};

        set_idle();
        reset = 1'b1;

        // Reset state and first clear.
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", DW'({busy_rf, busy_wf, busy_oq}), DW'(3'b111));
        chk("reset rq rf", rq_a_rf | rq_b_rf, '0);
        chk("reset rq wf", rq_a_wf | rq_b_wf, '0);
        chk("reset rq oq", rq_a_oq | rq_b_oq, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("init busy at release", DW'(busy_rf), DW'(1));
        wait_clear("init");

        // Vector table. The OUT_REG instance is READ_FIRST and all table
        // addresses are in range, so it shows the READ_FIRST value one edge late.
        prev_a = '0;
        prev_b = '0;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rq_a rf", i), rq_a_rf, vecs[i].ea_rf);
            chk($sformatf("v%0d rq_a wf", i), rq_a_wf, vecs[i].ea_wf);
            chk($sformatf("v%0d rq_b rf", i), rq_b_rf, vecs[i].eb_rf);
            chk($sformatf("v%0d rq_b wf", i), rq_b_wf, vecs[i].eb_wf);
            chk($sformatf("v%0d rq_a oq", i), rq_a_oq, prev_a);
            chk($sformatf("v%0d rq_b oq", i), rq_b_oq, prev_b);
            prev_a = vecs[i].ea_rf;
            prev_b = vecs[i].eb_rf;
        end

        // Two-cycle latency of the output-register instance.
        step(1'b1, 1'b0, 10'd50, 36'h0DEADBEEF, 1'b0, 10'd0);
        chk("lat write rq_a oq", rq_a_oq, 36'h555555555);
        step(1'b0, 1'b1, 10'd50, 36'h0, 1'b0, 10'd0);
        chk("lat edge1 rq_a rf", rq_a_rf, 36'h0DEADBEEF);
        chk("lat edge1 rq_a oq", rq_a_oq, 36'h555555555);
        step(1'b0, 1'b0, 10'd0, 36'h0, 1'b0, 10'd0);
        chk("lat edge2 rq_a oq", rq_a_oq, 36'h0DEADBEEF);

        // Pre-load words 0, 5, 1023 (1023 is out of range for the SIZE=1000 instance).
        step(1'b1, 1'b0, 10'd0,    36'h123456789, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd5,    36'h123456789, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd1023, 36'h123456789, 1'b0, 10'd0);
        step(1'b0, 1'b1, 10'd1023, 36'h0, 1'b1, 10'd5);
        chk("preload rq_a rf 1023", rq_a_rf, 36'h123456789);
        chk("preload rq_b rf 5",    rq_b_rf, 36'h123456789);
        step(1'b0, 1'b0, 10'd0, 36'h0, 1'b0, 10'd0);
        chk("oob rq_a oq 1023",     rq_a_oq, 36'h0);
        chk("preload rq_b oq 5",    rq_b_oq, 36'h123456789);

        // Clear sweep zeroes the array.
        do_reset(2, "clear");
        step(1'b0, 1'b1, 10'd0, 36'h0, 1'b1, 10'd5);
        chk("clear rq_a rf 0", rq_a_rf, 36'h0);
        chk("clear rq_b rf 5", rq_b_rf, 36'h0);
        step(1'b0, 1'b1, 10'd1023, 36'h0, 1'b0, 10'd0);
        chk("clear rq_a rf 1023", rq_a_rf, 36'h0);
        chk("clear rq_a wf 1023", rq_a_wf, 36'h0);

        // Put nonzero data on the outputs, then reset mid-sweep.
        step(1'b1, 1'b0, 10'd40, 36'h0FEDCBA98, 1'b0, 10'd0);
        step(1'b0, 1'b1, 10'd40, 36'h0, 1'b0, 10'd0);
        chk("pre-sweep rq_a rf", rq_a_rf, 36'h0FEDCBA98);
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("sweep rq_a rf zero", rq_a_rf, 36'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("mid-sweep busy", DW'({busy_rf, busy_wf, busy_oq}), DW'(3'b111));
        // A write attempted while busy must be ignored.
        @(negedge clk);
        wce_a = 1'b1; addr_a = 10'd900; be_a = 4'hF; wd_a = 36'h0CAFEF00D;
        @(negedge clk);
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("restart busy at release", DW'(busy_rf), DW'(1));
        wait_clear("restart");
        step(1'b0, 1'b1, 10'd40, 36'h0, 1'b1, 10'd900);
        chk("restart rq_a rf 40",  rq_a_rf, 36'h0);
        chk("restart rq_b rf 900", rq_b_rf, 36'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
